nand_read_seq_ctrl: RTL
=======================

Name: nand_read_seq_ctrl

Overview:
Parametrised multi-page NAND read sequencer. It reads a run of pages from a start block. Bad blocks are skipped automatically, and the controller advances to the next block. Each sector's ECC result is evaluated, and uncorrectable pages are retried a bounded number of times. The block sits between the host read-request logic and the low-level NAND timing/ECC engines, replacing the single-page read controller.

Parameters:
BLK_W, 12, block address width
PG_W, 6, page-in-block address width; PAGES_PER_BLOCK = 2**PG_W
SECTORS, 8, ECC sectors per page (power of two, 2..32); SEC_W = clog2(SECTORS)
CNT_W, 16, width of requested page count
MAX_RETRY, 2, page re-reads allowed after an uncorrectable sector (0..7)
TIMEOUT, 4095, cycles allowed per wait state before timeout abort

Ports:
clk  in  1  system clock
rst  in  1  reset
en_read  in  1  start pulse; sampled only in IDLE
start_block  in  BLK_W  first block; captured on en_read
page_count  in  CNT_W  pages to read; captured on en_read
bb_req  out  1  one-cycle bad-block lookup request for block_addr
bb_valid  in  1  lookup result valid
bb_bad  in  1  1 = block bad (qualified by bb_valid)
page_req  out  1  one-cycle page-read command for block_addr/page_addr
page_done  in  1  array-to-buffer transfer complete
ecc_valid  in  1  ecc_status valid for sector_idx
ecc_status  in  2  1 clean, 2 correctable, 3 uncorrectable; 0 ignored
fix_req  out  1  one-cycle correction request for sector_idx
fix_done  in  1  correction written back
block_addr  out  BLK_W  current block
page_addr  out  PG_W  current page
sector_idx  out  SEC_W  current sector
invalid_mask  out  SECTORS  uncorrectable sectors of the page just finished
page_out  out  1  one-cycle pulse: page finished, invalid_mask valid
read_state  out  4  state encoding below
busy  out  1  high when not IDLE
done  out  1  one-cycle completion pulse
err_uncorr  out  1  sticky per run: any page delivered with nonzero mask
err_timeout  out  1  sticky per run: run aborted by timeout

Behaviour:
Reset:
- All outputs are 0; state is IDLE; counters are 0.
- rst is asynchronous, active-high, and abandons any run mid-operation. No done pulse is issued.

States:
- IDLE(0): on en_read, capture start_block into block_addr; set page_addr=0, sector_idx=0, remaining=page_count, retry=0; clear err_* and invalid_mask. If page_count==0, go to DONE; otherwise go to BB_REQ.
- BB_REQ(1): assert bb_req for one cycle; go to BB_WAIT.
- BB_WAIT(2): on bb_valid, if bb_bad go to SKIP; otherwise go to PG_REQ.
- SKIP(3): block_addr+1 (wraps to 0 modulo 2**BLK_W); page_addr=0; go to BB_REQ. Skipped blocks do not decrement remaining.
- PG_REQ(4): assert page_req for one cycle; go to PG_WAIT.
- PG_WAIT(5): on page_done, set sector_idx=0 and go to ECC_WAIT.
- ECC_WAIT(6): on ecc_valid with ecc_status!=0, evaluate the status:
  - 1: go to SEC_NEXT.
  - 2: go to FIX.
  - 3: set invalid_mask[sector_idx]; go to SEC_NEXT.
- FIX(7): assert fix_req on entry cycle only. On fix_done, go to SEC_NEXT.
- SEC_NEXT(8): if sector_idx == SECTORS-1, go to PG_END; otherwise sector_idx+1 and go to ECC_WAIT.
- PG_END(9): if invalid_mask != 0 and retry < MAX_RETRY, retry+1, clear invalid_mask, go to PG_REQ (same page). Otherwise:
  - Pulse page_out.
  - If invalid_mask != 0, set err_uncorr.
  - retry=0; remaining-1.
  - If remaining becomes 0, go to DONE.
  - Otherwise page_addr+1. If page_addr wraps from PAGES_PER_BLOCK-1 to 0, block_addr+1 and go to BB_REQ; otherwise go to PG_REQ.
  - invalid_mask holds its value until the next page's first ECC_WAIT entry.
- DONE(10): pulse done; go to IDLE.
- TOUT(11): set err_timeout; go to DONE.

Timeout and concurrency:
- A wait counter clears on entry to BB_WAIT, PG_WAIT, ECC_WAIT, or FIX.
- If the awaited input does not arrive within TIMEOUT cycles, the FSM goes to TOUT.
- A response arriving on the same cycle the count reaches TIMEOUT wins over the timeout.
- en_read while busy is ignored.
- Responses in states not awaiting them (e.g. a stray page_done) are ignored.

Latency:
- en_read to bb_req: 2 cycles.
- Clean page with zero-delay responders: page_req to page_out = 2 + 2*SECTORS cycles.

Test Plan:
- start_block=5, page_count=3, all blocks good, all ecc_status=1 -> 3 page_out pulses with pages 0,1,2 of block 5; invalid_mask=0; done once; no errors.
- Block 5 bad, block 6 good, page_count=1 -> two bb_req pulses (5, then 6); page read at block 6 page 0; done.
- Sector 3 returns status 2 -> fix_req with sector_idx=3; FSM waits for fix_done, then continues to sector 4; mask=0.
- Sector 6 returns status 3 on every read, MAX_RETRY=2 -> 3 page_req for the same page; page_out with invalid_mask=0x40; err_uncorr=1.
- start_block=2**BLK_W-1, page_addr crossing PAGES_PER_BLOCK boundary, page_count=PAGES_PER_BLOCK+1 -> last page read at block 0 page 0.
- page_done withheld -> TOUT after TIMEOUT+1 cycles, err_timeout=1, done pulse. Assert rst mid-ECC_WAIT -> all outputs 0 immediately, no done.

Source files
------------

// File: rtl/nand_read_seq_ctrl.sv
// Multi-page NAND read sequencer: bad-block skipping, per-sector ECC evaluation,
// bounded page re-reads on uncorrectable sectors and per-wait-state timeout abort.
module nand_read_seq_ctrl #(
  parameter int unsigned BLK_W     = 12,
  parameter int unsigned PG_W      = 6,
  parameter int unsigned SECTORS   = 8,
  parameter int unsigned CNT_W     = 16,
  parameter int unsigned MAX_RETRY = 2,
  parameter int unsigned TIMEOUT   = 4095,
  localparam int unsigned SEC_W    = $clog2(SECTORS)
) (
  input  logic               clk,
  input  logic               rst,
  input  logic               en_read,
  input  logic [BLK_W-1:0]   start_block,
  input  logic [CNT_W-1:0]   page_count,
  output logic               bb_req,
  input  logic               bb_valid,
  input  logic               bb_bad,
  output logic               page_req,
  input  logic               page_done,
  input  logic               ecc_valid,
  input  logic [1:0]         ecc_status,
  output logic               fix_req,
  input  logic               fix_done,
  output logic [BLK_W-1:0]   block_addr,
  output logic [PG_W-1:0]    page_addr,
  output logic [SEC_W-1:0]   sector_idx,
  output logic [SECTORS-1:0] invalid_mask,
  output logic               page_out,
  output logic [3:0]         read_state,
  output logic               busy,
  output logic               done,
  output logic               err_uncorr,
  output logic               err_timeout
);

  localparam int unsigned TW = $clog2(TIMEOUT + 1);

  typedef enum logic [3:0] {
    StIdle    = 4'd0,
    StBbReq   = 4'd1,
    StBbWait  = 4'd2,
    StSkip    = 4'd3,
    StPgReq   = 4'd4,
    StPgWait  = 4'd5,
    StEccWait = 4'd6,
    StFix     = 4'd7,
    StSecNext = 4'd8,
    StPgEnd   = 4'd9,
    StDone    = 4'd10,
    StTout    = 4'd11
  } state_e;

  state_e             state_q, state_d;
  logic [BLK_W-1:0]   blk_q, blk_d;
  logic [PG_W-1:0]    pg_q, pg_d;
  logic [SEC_W-1:0]   sec_q, sec_d;
  logic [CNT_W-1:0]   rem_q, rem_d;
  logic [2:0]         retry_q, retry_d;
  logic [SECTORS-1:0] mask_q, mask_d;
  logic [TW-1:0]      wcnt_q, wcnt_d;
  logic               err_unc_q, err_unc_d;
  logic               err_to_q, err_to_d;
  logic               bb_req_q, bb_req_d;
  logic               page_req_q, page_req_d;
  logic               fix_req_q, fix_req_d;
  logic               page_out_q, page_out_d;
  logic               done_q, done_d;
  logic               waiting;
  logic               expired;

  assign waiting = (state_q == StBbWait) || (state_q == StPgWait) ||
                   (state_q == StEccWait) || (state_q == StFix);
  assign expired = (wcnt_q == TW'(TIMEOUT));

  always_comb begin
    state_d    = state_q;
    blk_d      = blk_q;
    pg_d       = pg_q;
    sec_d      = sec_q;
    rem_d      = rem_q;
    retry_d    = retry_q;
    mask_d     = mask_q;
    err_unc_d  = err_unc_q;
    err_to_d   = err_to_q;
    bb_req_d   = 1'b0;
    page_req_d = 1'b0;
    fix_req_d  = 1'b0;
    page_out_d = 1'b0;
    done_d     = 1'b0;

    // In every wait state the awaited response is tested before the timeout,
    // so a response on the expiring cycle still wins.
    unique case (state_q)
      StIdle: begin
        if (en_read) begin
          blk_d     = start_block;
          pg_d      = '0;
          sec_d     = '0;
          rem_d     = page_count;
          retry_d   = '0;
          mask_d    = '0;
          err_unc_d = 1'b0;
          err_to_d  = 1'b0;
          state_d   = (page_count == '0) ? StDone : StBbReq;
        end
      end
      StBbReq: begin
        bb_req_d = 1'b1;
        state_d  = StBbWait;
      end
      StBbWait: begin
        if (bb_valid) begin
          state_d = bb_bad ? StSkip : StPgReq;
        end else if (expired) begin
          state_d = StTout;
        end
      end
      StSkip: begin
        blk_d   = blk_q + BLK_W'(1);
        pg_d    = '0;
        state_d = StBbReq;
      end
      StPgReq: begin
        page_req_d = 1'b1;
        state_d    = StPgWait;
      end
      StPgWait: begin
        if (page_done) begin
          sec_d   = '0;
          mask_d  = '0;
          state_d = StEccWait;
        end else if (expired) begin
          state_d = StTout;
        end
      end
      StEccWait: begin
        if (ecc_valid && (ecc_status != 2'd0)) begin
          case (ecc_status)
            2'd2: begin
              fix_req_d = 1'b1;
              state_d   = StFix;
            end
            2'd3: begin
              mask_d[sec_q] = 1'b1;
              state_d       = StSecNext;
            end
            default: state_d = StSecNext;
          endcase
        end else if (expired) begin
          state_d = StTout;
        end
      end
      StFix: begin
        if (fix_done) begin
          state_d = StSecNext;
        end else if (expired) begin
          state_d = StTout;
        end
      end
      StSecNext: begin
        if (sec_q == SEC_W'(SECTORS - 1)) begin
          state_d = StPgEnd;
        end else begin
          sec_d   = sec_q + SEC_W'(1);
          state_d = StEccWait;
        end
      end
      StPgEnd: begin
        if ((mask_q != '0) && (retry_q < 3'(MAX_RETRY))) begin
          retry_d = retry_q + 3'd1;
          mask_d  = '0;
          state_d = StPgReq;
        end else begin
          page_out_d = 1'b1;
          if (mask_q != '0) begin
            err_unc_d = 1'b1;
          end
          retry_d = '0;
          rem_d   = rem_q - CNT_W'(1);
          if (rem_q == CNT_W'(1)) begin
            state_d = StDone;
          end else begin
            pg_d = pg_q + PG_W'(1);
            if (pg_q == {PG_W{1'b1}}) begin
              blk_d   = blk_q + BLK_W'(1);
              state_d = StBbReq;
            end else begin
              state_d = StPgReq;
            end
          end
        end
      end
      StDone: begin
        done_d  = 1'b1;
        state_d = StIdle;
      end
      StTout: begin
        err_to_d = 1'b1;
        state_d  = StDone;
      end
      default: state_d = StIdle;
    endcase

    if (state_d != state_q) begin
      wcnt_d = '0;
    end else if (waiting) begin
      wcnt_d = wcnt_q + TW'(1);
    end else begin
      wcnt_d = '0;
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q    <= StIdle;
      blk_q      <= '0;
      pg_q       <= '0;
      sec_q      <= '0;
      rem_q      <= '0;
      retry_q    <= '0;
      mask_q     <= '0;
      wcnt_q     <= '0;
      err_unc_q  <= 1'b0;
      err_to_q   <= 1'b0;
      bb_req_q   <= 1'b0;
      page_req_q <= 1'b0;
      fix_req_q  <= 1'b0;
      page_out_q <= 1'b0;
      done_q     <= 1'b0;
    end else begin
      state_q    <= state_d;
      blk_q      <= blk_d;
      pg_q       <= pg_d;
      sec_q      <= sec_d;
      rem_q      <= rem_d;
      retry_q    <= retry_d;
      mask_q     <= mask_d;
      wcnt_q     <= wcnt_d;
      err_unc_q  <= err_unc_d;
      err_to_q   <= err_to_d;
      bb_req_q   <= bb_req_d;
      page_req_q <= page_req_d;
      fix_req_q  <= fix_req_d;
      page_out_q <= page_out_d;
      done_q     <= done_d;
    end
  end

  // Strobes are registered; addresses stay stable while the matching wait state runs.
  assign bb_req       = bb_req_q;
  assign page_req     = page_req_q;
  assign fix_req      = fix_req_q;
  assign block_addr   = blk_q;
  assign page_addr    = pg_q;
  assign sector_idx   = sec_q;
  assign invalid_mask = mask_q;
  assign page_out     = page_out_q;
  assign read_state   = state_q;
  assign busy         = (state_q != StIdle);
  assign done         = done_q;
  assign err_uncorr   = err_unc_q;
  assign err_timeout  = err_to_q;

endmodule
